idct_out_buffer: RTL
====================

Name: idct_out_buffer

Overview:
- Stage directly downstream of the four-lane IDCT row pipeline.
- Accepts one row of four 24-bit IDCT results per handshake, then rounds, right-shifts and saturates each lane to a signed residual.
- Stores four rows as a 4x4 block in a ping-pong buffer and emits the block column by column (transposed), with valid/ready on both sides.
- One bank fills while the other drains, so throughput is sustained at one row or column per cycle.

Parameters:
- IN_W, 24, width of each input lane (two's complement).
- OUT_W, 9, width of each output lane (two's complement, saturated).
- SHIFT, 6, right-shift applied after rounding; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- in_valid  input  1  row on d_in_1..4 is valid.
- in_ready  output  1  buffer can accept a row this cycle.
- d_in_1..d_in_4  input  IN_W each  row lanes 0..3 (column index c = lane-1).
- out_valid  output  1  column on d_out_1..4 is valid.
- out_ready  input  1  downstream accepts the column.
- d_out_1..d_out_4  output  OUT_W each  column lanes; d_out_k is the element from row k-1.
- out_last  output  1  high with the 4th (final) column of a block.

Behaviour:
- Arithmetic per lane, in IN_W+1 bits:
  - r = (x + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Applied on the write path; the banks store OUT_W-bit values.
- Storage: two banks, each 4x4xOUT_W, each with a full flag.
- Write pointers: wbank (1 bit), wrow (2 bits).
- Read pointers: rbank (1 bit), rcol (2 bits).
- Write side:
  - in_ready = ~full[wbank], from registered state only; no combinational path from out_ready.
  - On in_valid & in_ready: bank[wbank].row[wrow] <= rounded lanes, and wrow increments.
  - When wrow==3 on that accept: set full[wbank], toggle wbank, wrow wraps to 0.
  - in_valid while in_ready is low: row ignored; upstream holds it.
- Read side:
  - out_valid = full[rbank].
  - d_out_k = bank[rbank].row[k-1].col[rcol].
  - out_last = out_valid & (rcol==3).
  - On out_valid & out_ready: rcol increments.
  - At rcol==3 on that accept: clear full[rbank], toggle rbank, rcol wraps to 0.
  - Outputs stay stable while out_valid & ~out_ready.
- Latency: column 0 is presented (out_valid=1) the cycle after the 4th row is accepted.
- Concurrency:
  - Writing bank A and reading bank B in the same cycle is legal and independent.
  - A bank cleared by its final read becomes writable the following cycle, via the registered full flag.
  - Result: with out_ready held high, in_ready never drops and the stream is gapless (4 rows in, 4 columns out per 4 cycles).
- Boundaries:
  - Both banks full: in_ready=0 until a block finishes draining.
  - Both banks empty: out_valid=0 and d_out reflects stale bank contents (don't-care).
  - A partial block (wrow != 0) is never emitted until its 4th row arrives.
- Reset (reset=0, any time, including mid-block or mid-drain):
  - full flags, wbank, wrow, rbank, rcol and bank contents all go to 0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_last=0, d_out_k=0.
  - Partial and undrained blocks are discarded.
  - Operation resumes on the first clk edge after reset returns to 1.

Test Plan:
- Transpose, full rate: in_valid=1, out_ready=1, four rows with lane c of row r = (16r+c)<<6 -> one cycle after row 3, four consecutive columns. Column c has d_out_k = 16(k-1)+c, e.g. column 2 = {2,18,34,50}. out_last on column 3 only; in_ready stays 1.
- Rounding: lanes {95, -96, 32, -33} in every row -> every column {1, -1, 1, -1}, i.e. 9'h001, 9'h1FF, 9'h001, 9'h1FF.
- Saturation: lanes {24'h7FFFFF, 24'h800000, 24'h003FC0, 24'hFFC000} -> {255, -256, 255, -256}, i.e. 9'h0FF, 9'h100, 9'h0FF, 9'h100.
- Backpressure: out_ready=0, present 9 rows -> in_ready falls after the 8th accept and the 9th row is held. Then raise out_ready -> block 1 drains (4 columns), the 9th row is accepted the cycle after block 1's out_last, and block 2 follows with no gap.
- Stall mid-drain: drop out_ready during column 1 for 3 cycles -> d_out and out_valid hold column 1 unchanged; draining resumes at column 1, with no skip and no duplicate.
- Reset mid-operation: after 2 rows of block 0 plus a full block 1 waiting, pull reset low for 1 cycle -> immediately out_valid=0, in_ready=1, d_out=0. Next 4 rows form a fresh block output first; no stale data ever appears.

Source files
------------

// File: rtl/idct_out_buffer.sv
// idct_out_buffer: rounds/saturates IDCT rows into a ping-pong 4x4 buffer
// and drains each block column by column (transposed).
module idct_out_buffer #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 9,
  parameter int SHIFT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  d_in_1,
  input  logic [IN_W-1:0]  d_in_2,
  input  logic [IN_W-1:0]  d_in_3,
  input  logic [IN_W-1:0]  d_in_4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] d_out_1,
  output logic [OUT_W-1:0] d_out_2,
  output logic [OUT_W-1:0] d_out_3,
  output logic [OUT_W-1:0] d_out_4,
  output logic             out_last
);
  logic [OUT_W-1:0] mem_q [2][4][4];
  logic [1:0]       full_q, full_d;
  logic             wbank_q, rbank_q;
  logic [1:0]       wrow_q, rcol_q;
  logic             wr, rd;
  logic [IN_W-1:0]  din [4];
  logic [OUT_W-1:0] rnd [4];

  // Rounding add is done one bit wider so the largest positive input cannot wrap.
  function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] s, hi, lo;
    hi = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    lo = ~hi;
    s = (signed'({x[IN_W-1], x}) + signed'((IN_W+1)'(1) << (SHIFT-1))) >>> SHIFT;
    return s > hi ? hi[OUT_W-1:0] : s < lo ? lo[OUT_W-1:0] : s[OUT_W-1:0];
  endfunction

  assign din = '{d_in_1, d_in_2, d_in_3, d_in_4};

  always_comb
    for (int c = 0; c < 4; c++) rnd[c] = round_sat(din[c]);

  assign in_ready  = ~full_q[wbank_q];
  assign out_valid = full_q[rbank_q];
  assign out_last  = out_valid & (&rcol_q);
  assign wr        = in_valid & in_ready;
  assign rd        = out_valid & out_ready;
  assign d_out_1   = mem_q[rbank_q][0][rcol_q];
  assign d_out_2   = mem_q[rbank_q][1][rcol_q];
  assign d_out_3   = mem_q[rbank_q][2][rcol_q];
  assign d_out_4   = mem_q[rbank_q][3][rcol_q];

  // Fill and drain always target different banks, so set and clear never collide.
  always_comb begin
    full_d = full_q;
    if (wr && &wrow_q) full_d[wbank_q] = 1'b1;
    if (rd && &rcol_q) full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_q   <= '{default: '0};
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wrow_q  <= '0;
      rcol_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wr) begin
        for (int c = 0; c < 4; c++) mem_q[wbank_q][wrow_q][c] <= rnd[c];
        wrow_q <= wrow_q + 2'd1;
        if (&wrow_q) wbank_q <= ~wbank_q;
      end
      if (rd) begin
        rcol_q <= rcol_q + 2'd1;
        if (&rcol_q) rbank_q <= ~rbank_q;
      end
    end
endmodule
